// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Ports: clk/rst; ID-side fields, operands and control; writeback port
//   (wb_we/wb_addr/wb_data); flush; stall (comb); ex_* registered outputs;
//   stall_count (saturating).
// Optional macro ID_EX_WB_BYPASS_EN: forward the writeback value into the
//   latched operands when it targets rs/rt in the same cycle.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [ADDR_W-1:0]  rs_addr,
    input  logic [ADDR_W-1:0]  rt_addr,
    input  logic               uses_rt,
    input  logic [ADDR_W-1:0]  dst_addr,
    input  logic [DATA_W-1:0]  rs_data,
    input  logic [DATA_W-1:0]  rt_data,
    input  logic [DATA_W-1:0]  imm,
    input  logic [DATA_W-1:0]  pc_plus4,
    input  logic               reg_write,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               mem_to_reg,
    input  logic               alu_src,
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic               wb_we,
    input  logic [ADDR_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               flush,
    output logic               stall,
    output logic               ex_valid,
    output logic [ADDR_W-1:0]  ex_rs_addr,
    output logic [ADDR_W-1:0]  ex_rt_addr,
    output logic [ADDR_W-1:0]  ex_dst_addr,
    output logic [DATA_W-1:0]  ex_rs_data,
    output logic [DATA_W-1:0]  ex_rt_data,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [DATA_W-1:0]  ex_pc_plus4,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [CNT_W-1:0]   stall_count
);

    logic              hazard;
    logic              rs_match;
    logic              rt_match;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    // A load in EX whose destination is read by the ID instruction.
    // r0 is hard-wired, so it never creates a dependency.
    assign rs_match = (ex_dst_addr == rs_addr);
    assign rt_match = uses_rt & (ex_dst_addr == rt_addr);
    assign hazard   = in_valid & ex_valid & ex_mem_read
                    & (ex_dst_addr != '0) & (rs_match | rt_match);
    assign stall    = hazard & ~flush & ~rst;

`ifdef ID_EX_WB_BYPASS_EN
    // Regfile write and read happen on the same edge; pick up the new value.
    assign rs_fwd = (wb_we && wb_addr != '0 && wb_addr == rs_addr)
                  ? wb_data : rs_data;
    assign rt_fwd = (wb_we && wb_addr != '0 && wb_addr == rt_addr)
                  ? wb_data : rt_data;
`else
    logic wb_unused;
    assign wb_unused = ^{wb_we, wb_addr, wb_data};
    assign rs_fwd    = rs_data;
    assign rt_fwd    = rt_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_rs_addr    <= '0;
            ex_rt_addr    <= '0;
            ex_dst_addr   <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_pc_plus4   <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_alu_op     <= '0;
            stall_count   <= '0;
        end else if (flush || hazard) begin
            // Bubble: only valid and side-effecting controls are cleared.
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            if (!flush && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
        end else begin
            ex_valid      <= in_valid;
            ex_rs_addr    <= rs_addr;
            ex_rt_addr    <= rt_addr;
            ex_dst_addr   <= dst_addr;
            ex_rs_data    <= rs_fwd;
            ex_rt_data    <= rt_fwd;
            ex_imm        <= imm;
            ex_pc_plus4   <= pc_plus4;
            ex_reg_write  <= reg_write & in_valid;
            ex_mem_read   <= mem_read & in_valid;
            ex_mem_write  <= mem_write & in_valid;
            ex_mem_to_reg <= mem_to_reg & in_valid;
            ex_alu_src    <= alu_src;
            ex_alu_op     <= alu_op;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage (stall counter built 4 bits wide).
// Covers reset, load, load-use stall, flush, r0, invalid slots, bypass, saturation.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = 4;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic          uses_rt;
    logic [AW-1:0] dst_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc_plus4;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          alu_src;
    logic [OW-1:0] alu_op;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          stall;
    logic          ex_valid;
    logic [AW-1:0] ex_rs_addr;
    logic [AW-1:0] ex_rt_addr;
    logic [AW-1:0] ex_dst_addr;
    logic [DW-1:0] ex_rs_data;
    logic [DW-1:0] ex_rt_data;
    logic [DW-1:0] ex_imm;
    logic [DW-1:0] ex_pc_plus4;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_mem_to_reg;
    logic          ex_alu_src;
    logic [OW-1:0] ex_alu_op;
    logic [CW-1:0] stall_count;

    int tests;
    int fails;
    int exp_cnt;

    id_ex_stage #(
        .DATA_W(DW), .ADDR_W(AW), .ALUOP_W(OW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .uses_rt(uses_rt),
        .dst_addr(dst_addr), .rs_data(rs_data), .rt_data(rt_data),
        .imm(imm), .pc_plus4(pc_plus4), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
        .ex_dst_addr(ex_dst_addr), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_pc_plus4(ex_pc_plus4), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
        .ex_alu_op(ex_alu_op), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        in_valid = 0; rs_addr = 0; rt_addr = 0; uses_rt = 0;
        dst_addr = 0; rs_data = 0; rt_data = 0; imm = 0;
        pc_plus4 = 0; reg_write = 0; mem_read = 0; mem_write = 0;
        mem_to_reg = 0; alu_src = 0; alu_op = 0; wb_we = 0;
        wb_addr = 0; wb_data = 0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Put a valid load to register d into EX.
    task automatic issue_load(input logic [AW-1:0] d);
        idle();
        in_valid = 1; rs_addr = 1; dst_addr = d;
        mem_read = 1; mem_to_reg = 1; reg_write = 1;
        step();
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'($urandom); rs_addr = AW'($urandom);
            rt_addr = AW'($urandom); uses_rt = 1'($urandom);
            dst_addr = AW'($urandom); rs_data = $urandom;
            rt_data = $urandom; imm = $urandom; pc_plus4 = $urandom;
            reg_write = 1'($urandom); mem_read = 1'($urandom);
            mem_write = 1'($urandom); mem_to_reg = 1'($urandom);
            alu_src = 1'($urandom); alu_op = OW'($urandom);
            wb_we = 1'($urandom); wb_addr = AW'($urandom);
            wb_data = $urandom; flush = 1'($urandom);
            step();
            tests++;
            if (stall !== 1'b0) begin
                fails++;
                $display("FAIL rst_stall got %0b want 0", stall);
            end
        end
        tests++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
             ex_mem_to_reg, ex_alu_src} !== 6'b0 ||
            {ex_rs_addr, ex_rt_addr, ex_dst_addr} !== '0 ||
            {ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4} !== '0 ||
            ex_alu_op !== '0) begin
            fails++;
            $display("FAIL rst_ex got valid=%0b rs=%h rt=%h want all 0",
                     ex_valid, ex_rs_data, ex_rt_data);
        end
        tests++;
        if (stall_count !== '0) begin
            fails++;
            $display("FAIL rst_cnt got %0d want 0", stall_count);
        end
        idle();
        rst = 0;
        exp_cnt = 0;
    endtask

    task automatic test_valid_add();
        idle();
        in_valid = 1; rs_addr = 3; rt_addr = 4; uses_rt = 1;
        rs_data = 32'h11; rt_data = 32'h22; dst_addr = 5;
        reg_write = 1; imm = 32'h100; pc_plus4 = 32'h1004;
        alu_op = 4'h2; alu_src = 1;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL add_stall got %0b want 0", stall);
        end
        step();
        tests++;
        if (ex_rs_data !== 32'h11 || ex_rt_data !== 32'h22) begin
            fails++;
            $display("FAIL add_data got %h/%h want 11/22",
                     ex_rs_data, ex_rt_data);
        end
        tests++;
        if (ex_dst_addr !== 5'd5 || ex_valid !== 1'b1 ||
            ex_reg_write !== 1'b1 || ex_mem_read !== 1'b0) begin
            fails++;
            $display("FAIL add_ctl got dst=%0d v=%0b rw=%0b mr=%0b want 5 1 1 0",
                     ex_dst_addr, ex_valid, ex_reg_write, ex_mem_read);
        end
        tests++;
        if (ex_imm !== 32'h100 || ex_pc_plus4 !== 32'h1004 ||
            ex_alu_op !== 4'h2 || ex_alu_src !== 1'b1 ||
            ex_rs_addr !== 5'd3 || ex_rt_addr !== 5'd4) begin
            fails++;
            $display("FAIL add_fields got imm=%h pc=%h op=%h",
                     ex_imm, ex_pc_plus4, ex_alu_op);
        end
    endtask

    task automatic test_load_use();
        issue_load(8);
        tests++;
        if (ex_mem_read !== 1'b1 || ex_dst_addr !== 5'd8) begin
            fails++;
            $display("FAIL lu_load got mr=%0b dst=%0d want 1 8",
                     ex_mem_read, ex_dst_addr);
        end
        idle();
        in_valid = 1; rs_addr = 8; rt_addr = 9; uses_rt = 1;
        dst_addr = 10; reg_write = 1; mem_write = 1;
        rs_data = 32'hAA; rt_data = 32'hBB;
        #1;
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL lu_stall got %0b want 1", stall);
        end
        step();
        exp_cnt = exp_cnt + 1;
        tests++;
        if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0 ||
            ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
            fails++;
            $display("FAIL lu_bubble got v=%0b mw=%0b rw=%0b want 0 0 0",
                     ex_valid, ex_mem_write, ex_reg_write);
        end
        tests++;
        if (stall_count !== CW'(exp_cnt)) begin
            fails++;
            $display("FAIL lu_cnt got %0d want %0d", stall_count, exp_cnt);
        end
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL lu_release got %0b want 0", stall);
        end
        step();
        tests++;
        if (ex_valid !== 1'b1 || ex_rs_addr !== 5'd8 ||
            ex_mem_write !== 1'b1 || ex_rs_data !== 32'hAA) begin
            fails++;
            $display("FAIL lu_held got v=%0b rs=%0d mw=%0b d=%h want 1 8 1 aa",
                     ex_valid, ex_rs_addr, ex_mem_write, ex_rs_data);
        end
        // Dependency through rt only counts when rt is actually read.
        issue_load(9);
        idle();
        in_valid = 1; rs_addr = 2; rt_addr = 9; uses_rt = 0;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL rt_unused got %0b want 0", stall);
        end
        uses_rt = 1;
        #1;
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL rt_used got %0b want 1", stall);
        end
        step();
        exp_cnt = exp_cnt + 1;
        tests++;
        if (ex_valid !== 1'b0 || stall_count !== CW'(exp_cnt)) begin
            fails++;
            $display("FAIL rt_bubble got v=%0b cnt=%0d want 0 %0d",
                     ex_valid, stall_count, exp_cnt);
        end
        step();
    endtask

    task automatic test_flush();
        issue_load(8);
        idle();
        in_valid = 1; rs_addr = 8; reg_write = 1; flush = 1;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL fl_stall got %0b want 0", stall);
        end
        step();
        tests++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 ||
            ex_mem_read !== 1'b0 || ex_mem_to_reg !== 1'b0) begin
            fails++;
            $display("FAIL fl_bubble got v=%0b rw=%0b mr=%0b want 0 0 0",
                     ex_valid, ex_reg_write, ex_mem_read);
        end
        tests++;
        if (stall_count !== CW'(exp_cnt)) begin
            fails++;
            $display("FAIL fl_cnt got %0d want %0d", stall_count, exp_cnt);
        end
        // Flush without any hazard still kills the slot.
        idle();
        in_valid = 1; rs_addr = 3; reg_write = 1; mem_write = 1; flush = 1;
        step();
        tests++;
        if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0) begin
            fails++;
            $display("FAIL fl_plain got v=%0b mw=%0b want 0 0",
                     ex_valid, ex_mem_write);
        end
    endtask

    task automatic test_r0();
        issue_load(0);
        idle();
        in_valid = 1; rs_addr = 0; rt_addr = 0; uses_rt = 1;
        rs_data = 32'h55; rt_data = 32'h66; dst_addr = 2;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL r0_stall got %0b want 0", stall);
        end
        step();
        tests++;
        if (ex_valid !== 1'b1 || ex_rs_data !== 32'h55 ||
            ex_rt_data !== 32'h66) begin
            fails++;
            $display("FAIL r0_pass got v=%0b %h/%h want 1 55/66",
                     ex_valid, ex_rs_data, ex_rt_data);
        end
    endtask

    task automatic test_invalid();
        issue_load(8);
        idle();
        in_valid = 0; rs_addr = 8; reg_write = 1; mem_read = 1;
        mem_write = 1; mem_to_reg = 1;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL inv_stall got %0b want 0", stall);
        end
        step();
        tests++;
        if ({ex_valid, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_mem_to_reg} !== 5'b0) begin
            fails++;
            $display("FAIL inv_ctl got %b want 00000",
                     {ex_valid, ex_reg_write, ex_mem_read,
                      ex_mem_write, ex_mem_to_reg});
        end
        tests++;
        if (stall_count !== CW'(exp_cnt)) begin
            fails++;
            $display("FAIL inv_cnt got %0d want %0d", stall_count, exp_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want_rs;
        logic [DW-1:0] want_rt;
        idle();
        in_valid = 1; rs_addr = 7; rt_addr = 7; uses_rt = 1;
        rs_data = 32'h1; rt_data = 32'h2; dst_addr = 3;
        wb_we = 1; wb_addr = 7; wb_data = 32'hDEAD;
`ifdef ID_EX_WB_BYPASS_EN
        want_rs = 32'hDEAD;
        want_rt = 32'hDEAD;
`else
        want_rs = 32'h1;
        want_rt = 32'h2;
`endif
        step();
        tests++;
        if (ex_rs_data !== want_rs || ex_rt_data !== want_rt) begin
            fails++;
            $display("FAIL byp_hit got %h/%h want %h/%h",
                     ex_rs_data, ex_rt_data, want_rs, want_rt);
        end
        // Address 0 is never forwarded.
        rs_addr = 0; rt_addr = 0; wb_addr = 0;
        rs_data = 32'h3; rt_data = 32'h4;
        step();
        tests++;
        if (ex_rs_data !== 32'h3 || ex_rt_data !== 32'h4) begin
            fails++;
            $display("FAIL byp_r0 got %h/%h want 3/4",
                     ex_rs_data, ex_rt_data);
        end
        // Non-matching address passes the regfile value.
        rs_addr = 6; rt_addr = 7; wb_addr = 7;
        rs_data = 32'h5; rt_data = 32'h6;
`ifdef ID_EX_WB_BYPASS_EN
        want_rt = 32'hDEAD;
`else
        want_rt = 32'h6;
`endif
        step();
        tests++;
        if (ex_rs_data !== 32'h5 || ex_rt_data !== want_rt) begin
            fails++;
            $display("FAIL byp_mix got %h/%h want 5/%h",
                     ex_rs_data, ex_rt_data, want_rt);
        end
        idle();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            issue_load(8);
            idle();
            in_valid = 1; rs_addr = 8;
            #1;
            tests++;
            if (stall !== 1'b1) begin
                fails++;
                $display("FAIL sat_stall[%0d] got %0b want 1", i, stall);
            end
            step();
            if (exp_cnt < 15) exp_cnt = exp_cnt + 1;
            tests++;
            if (stall_count !== CW'(exp_cnt)) begin
                fails++;
                $display("FAIL sat_cnt[%0d] got %0d want %0d",
                         i, stall_count, exp_cnt);
            end
        end
        tests++;
        if (stall_count !== 4'd15) begin
            fails++;
            $display("FAIL sat_final got %0d want 15", stall_count);
        end
        idle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_cnt = 0;
        idle();
        rst = 1;
        test_reset();
        test_valid_add();
        test_load_use();
        test_flush();
        test_r0();
        test_invalid();
        test_bypass();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage sitting directly downstream of the register file. It registers the decoded instruction fields, control bits and the two register-file read operands into the EX stage. It also performs load-use hazard detection: it drives a stall to PC/IF-ID and inserts a bubble. It honours a branch flush and keeps a saturating stall counter for performance debug.

Parameters:
DATA_W, 32, operand/immediate/PC width
ADDR_W, 5, register address width
ALUOP_W, 4, ALU operation code width
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  ID slot holds a real instruction
rs_addr  input  ADDR_W  source register 1 address, also drives regfile read_addr1
rt_addr  input  ADDR_W  source register 2 address, also drives regfile read_addr2
uses_rt  input  1  instruction reads rt as a source
dst_addr  input  ADDR_W  destination register
rs_data  input  DATA_W  regfile read_data1
rt_data  input  DATA_W  regfile read_data2
imm  input  DATA_W  sign-extended immediate
pc_plus4  input  DATA_W  PC+4 of ID instruction
reg_write, mem_read, mem_write, mem_to_reg, alu_src  input  1 each  decoded control
alu_op  input  ALUOP_W  decoded ALU op
wb_we  input  1  writeback write enable (same signals as regfile write port)
wb_addr  input  ADDR_W  writeback address
wb_data  input  DATA_W  writeback data
flush  input  1  kill the ID instruction (taken branch/jump)
stall  output  1  combinational; hold PC and IF/ID this cycle
ex_valid  output  1  EX slot valid
ex_rs_addr, ex_rt_addr, ex_dst_addr  output  ADDR_W  registered addresses
ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4  output  DATA_W  registered operands
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  output  1 each  registered control
ex_alu_op  output  ALUOP_W  registered ALU op
stall_count  output  CNT_W  number of bubble cycles inserted, saturating

Behaviour:
- Reset, sync: all ex_* outputs 0, ex_valid 0, stall_count 0. stall is combinational and may be 1 only if inputs demand it; during rst it is forced 0.
- hazard = in_valid & ex_valid & ex_mem_read & (ex_dst_addr != 0) & ((ex_dst_addr == rs_addr) | (uses_rt & ex_dst_addr == rt_addr)).
- stall = hazard & ~flush & ~rst.
- Per-edge priority: rst > flush > hazard > load.
  - flush: bubble.
  - hazard: bubble, stall_count += 1 unless already all-ones.
  - Otherwise: load all ex_* from inputs, ex_valid <= in_valid.
- Bubble means ex_valid, ex_reg_write, ex_mem_read, ex_mem_write and ex_mem_to_reg are set to 0. Data and address fields may hold any value; the verifier checks only control and valid bits on a bubble.
- If in_valid = 0 with no flush or hazard, the stage loads with ex_valid = 0 and all write/memory control bits forced to 0.
- Latency: exactly 1 cycle ID to EX. Exactly one bubble per load-use pair, because the next cycle's ex_valid is 0 and hazard clears.
- Register 0 never causes a hazard. Operand value for address 0 is passed through from rs_data/rt_data unmodified, since the regfile never writes r0.
- flush and hazard in the same cycle: flush wins. stall = 0 and the counter does not increment.
- Counter is saturating with no wrap. It is cleared only by rst.

Optional Feature:
ID_EX_WB_BYPASS_EN
- Defined: when wb_we = 1, wb_addr != 0 and wb_addr == rs_addr, the value loaded into ex_rs_data is wb_data instead of rs_data. The same rule applies to rt and ex_rt_data. This covers the regfile's same-edge write/read gap.
- Undefined: operands are always latched from rs_data/rt_data.
- Bypass never applies to bubbles or to address 0.

Test Plan:
- rst = 1 for 2 cycles with random inputs -> all ex_* = 0, ex_valid = 0, stall_count = 0, stall = 0.
- Valid add: rs = 3, rt = 4, rs_data = 0x11, rt_data = 0x22, dst = 5, reg_write = 1 -> next cycle ex_rs_data = 0x11, ex_rt_data = 0x22, ex_dst_addr = 5, ex_valid = 1.
- Load to r8 in EX (ex_mem_read = 1), ID reads rs = 8 -> stall = 1 that cycle; next cycle ex_valid = 0, ex_mem_write = 0, stall_count = 1. The held instruction then loads with stall = 0.
- Same load hazard with flush = 1 -> stall = 0, bubble inserted, stall_count unchanged. Also: load to r0 with rs = 0 -> no stall.
- Macro defined: wb_we = 1, wb_addr = 7, wb_data = 0xDEAD, rs = rt = 7, rs_data = 0x1 -> ex_rs_data = ex_rt_data = 0xDEAD. Macro undefined -> ex_rs_data = 0x1.
- With CNT_W = 4, force 20 load-use hazards -> stall_count reaches 15 and stays at 15.
